uart_rx_oversample: RTL and testbench

//   Robust UART 8N1 receiver for the far end of the uart_tx serial link; replacement for the baud-clocked receiver.

---
 rtl/uart_rx_oversample.sv | 141 ++++++++++++++
 tb/tb_uart_rx_oversample.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: oversampling UART 8N1 receiver; define UART_RX_PARITY_EN for 8E1 with parity_err
module uart_rx_oversample #(
    parameter int clock_frequency = 1000000,
    parameter int baud_rate       = 9600,
    parameter int OVERSAMPLE      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       donerx,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);
    localparam int DIV = clock_frequency / (baud_rate * OVERSAMPLE);
    localparam int DW = $clog2(DIV + 1);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [DW-1:0] DLAST = DW'(DIV - 1);
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    state_t        state_q;
    logic [DW-1:0] div_q, div_d;
    logic          tick;
    logic          rx_meta_q, rx_s_q, rx_prev_q;
    logic [TW-1:0] tick_cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shreg_q, dout_q;
    logic          donerx_q, frame_err_q, busy_q;
`ifdef UART_RX_PARITY_EN
    logic          parity_err_q, par_bad_q;
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif
    assign dout      = dout_q;
    assign donerx    = donerx_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
    // free-running tick divider: one tick every DIV clocks
    always_comb begin
        tick  = div_q == DLAST;
        div_d = tick ? '0 : div_q + DW'(1);
    end
    // divider register
    always_ff @(posedge clk) begin
        if (rst) div_q <= '0;
        else div_q <= div_d;
    end
    // two-flop synchroniser; rx_prev holds the previous tick's sample for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            if (tick) rx_prev_q <= rx_s_q;
        end
    end
    // receive FSM with registered byte, strobes and busy
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            dout_q       <= '0;
            donerx_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
            par_bad_q    <= 1'b0;
`endif
        end else begin
            donerx_q    <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (tick) begin
                case (state_q)
                    S_IDLE: begin
                        if (rx_prev_q && !rx_s_q) begin
                            state_q    <= S_START;
                            tick_cnt_q <= '0;
                            busy_q     <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (tick_cnt_q == HALF) begin
                            tick_cnt_q <= '0;
                            bit_cnt_q  <= '0;
                            state_q    <= rx_s_q ? S_IDLE : S_DATA;
                            busy_q     <= !rx_s_q;
                        end else tick_cnt_q <= tick_cnt_q + TW'(1);
                    end
                    S_DATA: begin
                        if (tick_cnt_q == LAST) begin
                            tick_cnt_q <= '0;
                            shreg_q    <= {rx_s_q, shreg_q[7:1]};
                            bit_cnt_q  <= bit_cnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                            if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
`else
                            if (bit_cnt_q == 3'd7) state_q <= S_STOP;
`endif
                        end else tick_cnt_q <= tick_cnt_q + TW'(1);
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (tick_cnt_q == LAST) begin
                            tick_cnt_q <= '0;
                            par_bad_q  <= rx_s_q ^ (^shreg_q);
                            state_q    <= S_STOP;
                        end else tick_cnt_q <= tick_cnt_q + TW'(1);
                    end
`endif
                    S_STOP: begin
                        if (tick_cnt_q == LAST) begin
                            tick_cnt_q <= '0;
                            state_q    <= S_IDLE;
                            busy_q     <= 1'b0;
                            if (rx_s_q) begin
                                dout_q   <= shreg_q;
                                donerx_q <= 1'b1;
                            end else frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= par_bad_q;
`endif
                        end else tick_cnt_q <= tick_cnt_q + TW'(1);
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample: directed and randomized frames against a byte-level receiver model
module tb_uart_rx_oversample;
    localparam int BIT = 96;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] dout;
    logic       donerx, frame_err, parity_err, busy;
    int checks = 0, errors = 0;
    int ndone = 0, nfe = 0, npe = 0, nbusy = 0, viol = 0;
    int exp_done = 0, exp_fe = 0, exp_pe = 0;
    logic [7:0] exp_dout = 8'h00;
    logic [7:0] got_q[$];
    logic pd = 1'b0, pf = 1'b0, pb = 1'b0;
    int lat;

    uart_rx_oversample dut (
        .clk(clk), .rst(rst), .rx(rx), .dout(dout), .donerx(donerx),
        .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // strobe monitor: counts pulses and records strobe-shape violations
    always @(negedge clk) begin
        if (donerx === 1'b1) begin
            ndone++;
            got_q.push_back(dout);
        end
        if (frame_err === 1'b1) nfe++;
        if (parity_err === 1'b1) npe++;
        if (busy === 1'b1 && !pb) nbusy++;
        if (donerx === 1'b1 && frame_err === 1'b1) viol++;
        if ((donerx === 1'b1 && pd) || (frame_err === 1'b1 && pf)) viol++;
        if (parity_err === 1'b1 && !(donerx === 1'b1 || frame_err === 1'b1)) viol++;
        pd = (donerx === 1'b1);
        pf = (frame_err === 1'b1);
        pb = (busy === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input logic stop, input logic par);
`ifdef UART_RX_PARITY_EN
        return {stop, par, b, 1'b0};
`else
        return {1'b0, stop, b, 1'b0} | {10'b0, par & 1'b0};
`endif
    endfunction

    // drives one frame from the current negedge; leaves rx at the stop level
    task automatic send(input logic [10:0] f);
        rx = 1'b0;
        lat = -1;
        for (int c = 1; c <= BIT; c++) begin
            @(negedge clk);
            if (busy === 1'b1 && lat < 0) lat = c;
        end
        for (int k = 1; k < NB; k++) begin
            rx = f[k];
            repeat (BIT) @(negedge clk);
        end
    endtask

    // updates the byte-level model for a frame with the given stop and parity correctness
    task automatic model(input logic [7:0] b, input logic stop, input logic par_ok);
        if (stop) begin
            exp_done++;
            exp_dout = b;
        end else exp_fe++;
`ifdef UART_RX_PARITY_EN
        if (!par_ok) exp_pe++;
`else
        if (par_ok && 1'b0) exp_pe++;
`endif
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_done"}, ndone, exp_done);
        chk({tag, "_ferr"}, nfe, exp_fe);
        chk({tag, "_perr"}, npe, exp_pe);
        chk({tag, "_dout"}, {24'b0, dout}, {24'b0, exp_dout});
    endtask

    initial begin
        logic [7:0] b;
        logic stop;
        int gap, n0, b0;
        bit seen;
        rst = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_dout", {24'b0, dout}, 0);
        chk("rst_donerx", {31'b0, donerx}, 0);
        chk("rst_frame_err", {31'b0, frame_err}, 0);
        chk("rst_parity_err", {31'b0, parity_err}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("idle_busy", {31'b0, busy}, 0);
        chk("idle_busy_starts", nbusy, 0);
        check_frame("idle");

        send(frame(8'hA5, 1'b1, ^8'hA5));
        model(8'hA5, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        chk("a5_busy_latency_ok", {31'b0, (lat >= 1 && lat <= 12)}, 1);
        check_frame("a5");
        chk("a5_captured", {24'b0, got_q[got_q.size()-1]}, 32'hA5);
        chk("a5_busy_after", {31'b0, busy}, 0);

        rx = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy === 1'b1) seen = 1;
        end
        rx = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (busy === 1'b1) seen = 1;
        end
        chk("glitch_busy_seen", {31'b0, seen}, 1);
        chk("glitch_busy_end", {31'b0, busy}, 0);
        check_frame("glitch");

        send(frame(8'h3C, 1'b0, ^8'h3C));
        model(8'h3C, 1'b0, 1'b1);
        b0 = nbusy;
        repeat (10 * BIT) @(negedge clk);
        check_frame("break");
        chk("break_no_retrigger", nbusy, b0);
        chk("break_busy", {31'b0, busy}, 0);
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
        send(frame(8'h81, 1'b1, ^8'h81));
        model(8'h81, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check_frame("after_break");

        n0 = got_q.size();
        send(frame(8'h00, 1'b1, ^8'h00));
        model(8'h00, 1'b1, 1'b1);
        send(frame(8'hFF, 1'b1, ^8'hFF));
        model(8'hFF, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check_frame("b2b");
        chk("b2b_first", {24'b0, got_q[n0]}, 32'h00);
        chk("b2b_second", {24'b0, got_q[n0+1]}, 32'hFF);

        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            rx = k[0] ? 1'b1 : 1'b0;
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_dout = 8'h00;
        repeat (200) @(negedge clk);
        check_frame("abort");
        chk("abort_busy", {31'b0, busy}, 0);
        send(frame(8'h5A, 1'b1, ^8'h5A));
        model(8'h5A, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check_frame("after_abort");

`ifdef UART_RX_PARITY_EN
        send(frame(8'h07, 1'b1, 1'b0));
        model(8'h07, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check_frame("parity_bad");
        send(frame(8'h07, 1'b1, 1'b1));
        model(8'h07, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check_frame("parity_good");
`endif

        rx = 1'b1;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            gap = stop ? $urandom_range(0, 150) : $urandom_range(100, 200);
            send(frame(b, stop, ^b));
            model(b, stop, 1'b1);
            check_frame($sformatf("rand%0d", i));
            rx = 1'b1;
            repeat (gap) @(negedge clk);
        end
        repeat (BIT) @(negedge clk);
        chk("strobe_shape", viol, 0);
        chk("final_busy", {31'b0, busy}, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
